// File: rtl/input_buffer_sub.sv
// Per-port router input FIFO: show-ahead head flit to route computation,
// occupancy published as backpressure pressure, sticky overflow flag.
module input_buffer_sub #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DATASIZE = 40
) (
  input  logic                buf_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out,
  output logic                overflow_err
);

  localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic [WIDTH:0]      count;
  logic                push;
  logic                pop;

  always_comb begin
    ready_out    = (count != FULL_COUNT);
    valid_out    = (count != '0);
    push         = valid_in & ready_out;
    pop          = rc_ready & valid_out;
    data_out     = mem[rd_ptr];
    pressure_out = count;
  end

  // Memory is cleared on reset so data_out is never X while empty.
  always_ff @(posedge buf_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (valid_in && !ready_out) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_buffer_sub.sv
// Directed bench for input_buffer_sub: reset, fill/drain, overflow, full/empty
// corner cases, wrap-around streaming against a queue, and mid-stream reset.
module tb_input_buffer_sub;

  logic        buf_clk = 1'b0;
  logic        rst_n;
  logic [39:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [39:0] data_out;
  logic        valid_out;
  logic        rc_ready;
  logic [3:0]  pressure_out;
  logic        overflow_err;

  int checks   = 0;
  int failures = 0;

  logic [39:0] q [$];
  int          sent;
  logic        do_push;
  logic        do_pop;

  input_buffer_sub #(.DEPTH(8), .WIDTH(3), .DATASIZE(40)) dut (
    .buf_clk      (buf_clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .rc_ready     (rc_ready),
    .pressure_out (pressure_out),
    .overflow_err (overflow_err)
  );

  always #5 buf_clk = ~buf_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge buf_clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b1;
    data_in  = 40'h77;
    rc_ready = 1'b0;
    #3;
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_press", pressure_out, 0);
    check("rst_data", data_out, 0);
    check("rst_ovf", overflow_err, 0);
    step();
    step();
    check("rst_hold_press", pressure_out, 0);
    valid_in = 1'b0;
    rst_n    = 1'b1;
    step();
    step();
    check("idle_press", pressure_out, 0);
    check("idle_valid", valid_out, 0);

    // Fill 8 flits with no consumer
    for (int i = 1; i <= 8; i++) begin
      valid_in = 1'b1;
      data_in  = 40'(i);
      step();
      check("fill_press", pressure_out, 64'(i));
      check("fill_ready", ready_out, (i != 8) ? 1 : 0);
      check("fill_head", data_out, 1);
    end

    // Offer while full: dropped, sticky error
    data_in = 40'hFF;
    step();
    check("ovf_press", pressure_out, 8);
    check("ovf_flag", overflow_err, 1);
    valid_in = 1'b0;
    step();
    check("ovf_sticky", overflow_err, 1);

    // Full with simultaneous pop: pop taken, push refused
    valid_in = 1'b1;
    data_in  = 40'hEE;
    rc_ready = 1'b1;
    check("fullpop_head", data_out, 1);
    step();
    check("fullpop_press", pressure_out, 7);
    check("fullpop_ready", ready_out, 1);

    valid_in = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      check("drain_data", data_out, 64'(i));
      step();
      check("drain_press", pressure_out, 64'(8 - i));
    end
    check("drain_valid", valid_out, 0);
    check("drain_ovf", overflow_err, 1);
    step();
    check("empty_pop_press", pressure_out, 0);

    // Empty with rc_ready: flit is stored, no underflow
    valid_in = 1'b1;
    data_in  = 40'h2A;
    rc_ready = 1'b1;
    step();
    check("empty_push_press", pressure_out, 1);
    check("empty_push_valid", valid_out, 1);
    check("empty_push_data", data_out, 40'h2A);
    valid_in = 1'b0;
    step();
    check("empty_push_drain", pressure_out, 0);

    // Stream 20 flits, rc_ready toggling; refused flits are re-offered
    sent = 0;
    q.delete();
    for (int c = 0; c < 200 && (sent < 20 || q.size() > 0); c++) begin
      valid_in = (sent < 20);
      data_in  = 40'hC0_0000_0000 | 40'(sent);
      rc_ready = (c % 2) == 1;
      do_push  = valid_in && (q.size() < 8);
      do_pop   = rc_ready && (q.size() > 0);
      if (do_pop) check("stream_data", data_out, q[0]);
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(data_in);
        sent++;
      end
      check("stream_press", pressure_out, 64'(q.size()));
    end
    check("stream_done", (sent == 20) && (q.size() == 0), 1);

    // Reset with 5 flits stored
    valid_in = 1'b1;
    rc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 40'h10 + 40'(i);
      step();
    end
    check("pre_rst_press", pressure_out, 5);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_valid", valid_out, 0);
    check("midrst_press", pressure_out, 0);
    check("midrst_data", data_out, 0);
    check("midrst_ovf", overflow_err, 0);
    step();
    rst_n    = 1'b1;
    valid_in = 1'b1;
    data_in  = 40'h5A;
    step();
    valid_in = 1'b0;
    check("post_rst_data", data_out, 40'h5A);
    check("post_rst_press", pressure_out, 1);
    rc_ready = 1'b1;
    step();
    check("post_rst_drain", pressure_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
